// File: rtl/pipelined_prefix_adder.sv
// Pipelined Kogge-Stone adder/subtractor.
// The carry-in rides along as an extra generate term below bit 0, so each
// prefix level spans WIDTH+1 positions. Register banks sit after every
// REGISTER_EVERY levels and after the last level. A final output register
// forms the sum, flags and valid. One global advance signal stalls every stage.
module pipelined_prefix_adder #(
    parameter int WIDTH          = 32,
    parameter int REGISTER_EVERY = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] source_element_0,
    input  logic [WIDTH-1:0] source_element_1,
    input  logic             input_carry,
    input  logic [1:0]       operation,
    input  logic             input_valid,
    output logic             input_ready,
    output logic [WIDTH-1:0] result,
    output logic             output_carry,
    output logic             overflow,
    output logic             zero,
    output logic             output_valid,
    input  logic             output_ready
);

    localparam int LOG2W = $clog2(WIDTH);

    // A register bank follows prefix level k when this returns 1.
    function automatic logic bank_after(input int k);
        return ((k + 1) % REGISTER_EVERY == 0) || (k == LOG2W - 1);
    endfunction

    logic             advance_s;
    logic             c0_s;
    logic [WIDTH-1:0] b_eff_s;
    logic [WIDTH:0]   g_in_s;
    logic [WIDTH:0]   p_in_s;

    logic [WIDTH:0]   bank_g_d_s  [LOG2W];
    logic [WIDTH:0]   bank_p_d_s  [LOG2W];
    logic [WIDTH:0]   bank_po_d_s [LOG2W];
    logic             bank_v_d_s  [LOG2W];
    logic [WIDTH:0]   bank_g_r    [LOG2W];
    logic [WIDTH:0]   bank_p_r    [LOG2W];
    logic [WIDTH:0]   bank_po_r   [LOG2W];
    logic             bank_v_r    [LOG2W];

    logic [WIDTH:0]   fin_g_s;
    logic [WIDTH:0]   fin_p_s;
    logic [WIDTH:0]   fin_po_s;
    logic             fin_v_s;
    logic [WIDTH-1:0] sum_s;
    logic             carry_s;
    logic             ovf_s;

    logic [WIDTH-1:0] result_r;
    logic             output_carry_r;
    logic             overflow_r;
    logic             zero_r;
    logic             output_valid_r;

    assign advance_s    = ~output_valid_r | output_ready;
    assign input_ready  = advance_s;
    assign result       = result_r;
    assign output_carry = output_carry_r;
    assign overflow     = overflow_r;
    assign zero         = zero_r;
    assign output_valid = output_valid_r;

    // Operand conditioning: invert B and force carry-in for subtract, then seed g/p.
    always_comb begin
        case (operation)
            2'b01:   c0_s = 1'b1;
            2'b10:   c0_s = input_carry;
            default: c0_s = 1'b0;
        endcase
        if (operation == 2'b01) begin
            b_eff_s = ~source_element_1;
        end else begin
            b_eff_s = source_element_1;
        end
        g_in_s = {source_element_0 & b_eff_s, c0_s};
        p_in_s = {source_element_0 ^ b_eff_s, 1'b0};
    end

    // Prefix network: black cells via shifted vectors; banked levels feed the next level from registers.
    always_comb begin
        logic [WIDTH:0] cur_g_s;
        logic [WIDTH:0] cur_p_s;
        logic [WIDTH:0] cur_po_s;
        logic           cur_v_s;
        logic [WIDTH:0] nxt_g_s;
        logic [WIDTH:0] nxt_p_s;
        logic [WIDTH:0] low_mask_s;
        cur_g_s  = g_in_s;
        cur_p_s  = p_in_s;
        cur_po_s = p_in_s;
        cur_v_s  = input_valid;
        for (int k = 0; k < LOG2W; k++) begin
            // Positions below the span distance are white cells and keep their p.
            low_mask_s = ~({(WIDTH + 1){1'b1}} << (1 << k));
            nxt_g_s    = cur_g_s | (cur_p_s & (cur_g_s << (1 << k)));
            nxt_p_s    = cur_p_s & ((cur_p_s << (1 << k)) | low_mask_s);
            bank_g_d_s[k]  = nxt_g_s;
            bank_p_d_s[k]  = nxt_p_s;
            bank_po_d_s[k] = cur_po_s;
            bank_v_d_s[k]  = cur_v_s;
            if (bank_after(k)) begin
                cur_g_s  = bank_g_r[k];
                cur_p_s  = bank_p_r[k];
                cur_po_s = bank_po_r[k];
                cur_v_s  = bank_v_r[k];
            end else begin
                cur_g_s  = nxt_g_s;
                cur_p_s  = nxt_p_s;
            end
        end
        fin_g_s  = cur_g_s;
        fin_p_s  = cur_p_s;
        fin_po_s = cur_po_s;
        fin_v_s  = cur_v_s;
    end

    // Sum and flags. The top position's group stops one short of the carry-in
    // term after LOG2W levels, so the carry-in is folded in here.
    always_comb begin
        sum_s   = fin_po_s[WIDTH:1] ^ fin_g_s[WIDTH-1:0];
        carry_s = fin_g_s[WIDTH] | (fin_p_s[WIDTH] & fin_g_s[0]);
        ovf_s   = carry_s ^ fin_g_s[WIDTH-1];
    end

    // Prefix register banks: shift together on advance, discard everything on reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < LOG2W; k++) begin
                bank_g_r[k]  <= {(WIDTH + 1){1'b0}};
                bank_p_r[k]  <= {(WIDTH + 1){1'b0}};
                bank_po_r[k] <= {(WIDTH + 1){1'b0}};
                bank_v_r[k]  <= 1'b0;
            end
        end else if (advance_s) begin
            for (int k = 0; k < LOG2W; k++) begin
                bank_g_r[k]  <= bank_g_d_s[k];
                bank_p_r[k]  <= bank_p_d_s[k];
                bank_po_r[k] <= bank_po_d_s[k];
                bank_v_r[k]  <= bank_v_d_s[k];
            end
        end
    end

    // Output register: holds the presented result while the consumer stalls.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            result_r       <= {WIDTH{1'b0}};
            output_carry_r <= 1'b0;
            overflow_r     <= 1'b0;
            zero_r         <= 1'b0;
            output_valid_r <= 1'b0;
        end else if (advance_s) begin
            result_r       <= sum_s;
            output_carry_r <= carry_s;
            overflow_r     <= ovf_s;
            zero_r         <= ~|sum_s;
            output_valid_r <= fin_v_s;
        end
    end

endmodule

// File: tb/tb_pipelined_prefix_adder.sv
// Bench for pipelined_prefix_adder: default instance plus 8/1, 16/4 and 64/3 instances.
module tb_pipelined_prefix_adder;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] a64, b64;
    logic        cin;
    logic [1:0]  op;
    logic        iv;
    logic        ordy;

    logic        ir, oc, ovf, zr, ov;
    logic [31:0] res;
    logic        ir8, oc8, ovf8, z8, ov8;
    logic [7:0]  res8;
    logic        ir16, oc16, ovf16, z16, ov16;
    logic [15:0] res16;
    logic        ir64, oc64, ovf64, z64, ov64;
    logic [63:0] res64;

    int n_cmp = 0;
    int n_bad = 0;
    logic done = 1'b0;

    logic [66:0] exp_q[$];
    logic [31:0] got_q[$];
    logic        hold = 1'b0;
    logic [34:0] held;

    always #5 clk = ~clk;

    pipelined_prefix_adder #(.WIDTH(32), .REGISTER_EVERY(2)) dut (
        .clock(clk), .reset(rst), .source_element_0(a64[31:0]), .source_element_1(b64[31:0]),
        .input_carry(cin), .operation(op), .input_valid(iv), .input_ready(ir),
        .result(res), .output_carry(oc), .overflow(ovf), .zero(zr),
        .output_valid(ov), .output_ready(ordy));

    pipelined_prefix_adder #(.WIDTH(8), .REGISTER_EVERY(1)) dut8 (
        .clock(clk), .reset(rst), .source_element_0(a64[7:0]), .source_element_1(b64[7:0]),
        .input_carry(cin), .operation(op), .input_valid(iv), .input_ready(ir8),
        .result(res8), .output_carry(oc8), .overflow(ovf8), .zero(z8),
        .output_valid(ov8), .output_ready(ordy));

    pipelined_prefix_adder #(.WIDTH(16), .REGISTER_EVERY(4)) dut16 (
        .clock(clk), .reset(rst), .source_element_0(a64[15:0]), .source_element_1(b64[15:0]),
        .input_carry(cin), .operation(op), .input_valid(iv), .input_ready(ir16),
        .result(res16), .output_carry(oc16), .overflow(ovf16), .zero(z16),
        .output_valid(ov16), .output_ready(ordy));

    pipelined_prefix_adder #(.WIDTH(64), .REGISTER_EVERY(3)) dut64 (
        .clock(clk), .reset(rst), .source_element_0(a64), .source_element_1(b64),
        .input_carry(cin), .operation(op), .input_valid(iv), .input_ready(ir64),
        .result(res64), .output_carry(oc64), .overflow(ovf64), .zero(z64),
        .output_valid(ov64), .output_ready(ordy));

    task automatic chk(string name, logic [66:0] act, logic [66:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: plain modular arithmetic. Packed as {zero, overflow, carry, result}.
    function automatic logic [66:0] model(int w, logic [63:0] a, logic [63:0] b,
                                          logic [1:0] o, logic c);
        logic [63:0] mask, bb, r;
        logic [64:0] s;
        logic        cc, cy, vf;
        mask = {64{1'b1}} >> (64 - w);
        a    = a & mask;
        bb   = ((o == 2'b01) ? ~b : b) & mask;
        cc   = (o == 2'b01) ? 1'b1 : ((o == 2'b10) ? c : 1'b0);
        s    = {1'b0, a} + {1'b0, bb} + {64'd0, cc};
        r    = s[63:0] & mask;
        cy   = s[w];
        vf   = (a[w-1] == bb[w-1]) && (r[w-1] != a[w-1]);
        return {(r == 64'd0), vf, cy, r};
    endfunction

    function automatic logic [63:0] pick();
        case ($urandom_range(0, 4))
            0: return 64'h0000_0000_FFFF_FFFF;
            1: return 64'h0000_0000_8000_0000;
            2: return 64'h0000_0000_7FFF_FFFF;
            3: return 64'd0;
            default: return {$urandom(), $urandom()};
        endcase
    endfunction

    // Scoreboard and handshake checks on the main instance, sampled mid-cycle.
    always @(negedge clk) begin
        logic [66:0] e;
        if (rst) begin
            exp_q.delete();
            hold = 1'b0;
        end else begin
            chk("input_ready_rule", ir, !ov || ordy);
            if (hold) begin
                chk("stall_valid_held", ov, 1'b1);
                chk("stall_fields_stable", {oc, ovf, zr, res}, held);
            end
            if (ov && ordy) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_output: got result %0h with nothing outstanding", res);
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_result", res, e[31:0]);
                    chk("sb_carry", oc, e[64]);
                    chk("sb_overflow", ovf, e[65]);
                    chk("sb_zero", zr, e[66]);
                    got_q.push_back(res);
                end
            end
            if (iv && ir) exp_q.push_back(model(32, a64, b64, op, cin));
            hold = ov && !ordy;
            held = {oc, ovf, zr, res};
        end
    end

    // Drive one transfer; called at posedge+1, returns at posedge+1 after acceptance.
    task automatic send(logic [63:0] a, logic [63:0] b, logic [1:0] o, logic c);
        int n;
        a64 = a; b64 = b; op = o; cin = c; iv = 1'b1;
        n = 0;
        @(negedge clk);
        while (!ir && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("send_accept", ir, 1'b1);
        @(posedge clk);
        #1 iv = 1'b0;
    endtask

    // Single op into empty pipes of all four instances; checks latency and values.
    task automatic run_all(string name, logic [63:0] a, logic [63:0] b, logic [1:0] o, logic c,
                           logic [31:0] er, logic ec, logic eo, logic ez);
        int          lat[4];
        logic [66:0] cap[4];
        for (int d = 0; d < 4; d++) begin
            lat[d] = 0;
            cap[d] = 'x;
        end
        @(posedge clk);
        #1 a64 = a; b64 = b; op = o; cin = c; iv = 1'b1;
        @(negedge clk);
        chk({name, "_ready"}, {ir, ir8, ir16, ir64}, 4'b1111);
        @(posedge clk);
        #1 iv = 1'b0;
        for (int cyc = 2; cyc <= 12; cyc++) begin
            @(posedge clk);
            #1;
            if (ov && lat[0] == 0)   begin lat[0] = cyc; cap[0] = {zr, ovf, oc, 32'd0, res}; end
            if (ov8 && lat[1] == 0)  begin lat[1] = cyc; cap[1] = {z8, ovf8, oc8, 56'd0, res8}; end
            if (ov16 && lat[2] == 0) begin lat[2] = cyc; cap[2] = {z16, ovf16, oc16, 48'd0, res16}; end
            if (ov64 && lat[3] == 0) begin lat[3] = cyc; cap[3] = {z64, ovf64, oc64, res64}; end
        end
        chk({name, "_lat_32_2"}, lat[0], 4);
        chk({name, "_lat_8_1"}, lat[1], 4);
        chk({name, "_lat_16_4"}, lat[2], 2);
        chk({name, "_lat_64_3"}, lat[3], 3);
        chk({name, "_result"}, cap[0][31:0], er);
        chk({name, "_carry"}, cap[0][64], ec);
        chk({name, "_overflow"}, cap[0][65], eo);
        chk({name, "_zero"}, cap[0][66], ez);
        chk({name, "_w8"}, cap[1], model(8, a, b, o, c));
        chk({name, "_w16"}, cap[2], model(16, a, b, o, c));
        chk({name, "_w64"}, cap[3], model(64, a, b, o, c));
    endtask

    task automatic drain(string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(posedge clk);
            #1 n++;
        end
        chk(name, exp_q.size(), 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; iv = 1'b0; a64 = 64'd0; b64 = 64'd0; op = 2'b00; cin = 1'b0; ordy = 1'b1;
        #2;
        chk("reset_outputs", {ov, oc, ovf, zr, res}, 36'd0);
        chk("reset_valid_others", {ov8, ov16, ov64}, 3'b000);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Carry wrap, subtract with and without borrow, overflow, carry-in modes.
        run_all("add_wrap", 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 2'b00, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
        run_all("sub_borrow", 64'd5, 64'd7, 2'b01, 1'b0, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
        run_all("sub_noborrow", 64'd7, 64'd5, 2'b01, 1'b0, 32'h0000_0002, 1'b1, 1'b0, 1'b0);
        run_all("add_ovf", 64'h7FFF_FFFF, 64'd1, 2'b00, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
        run_all("cin_used", 64'd0, 64'd0, 2'b10, 1'b1, 32'h0000_0001, 1'b0, 1'b0, 1'b0);
        run_all("cin_ignored", 64'd0, 64'd0, 2'b00, 1'b1, 32'h0000_0000, 1'b0, 1'b0, 1'b1);
        run_all("reserved_add", 64'd3, 64'd4, 2'b11, 1'b1, 32'h0000_0007, 1'b0, 1'b0, 1'b0);

        // Back-pressure: eight back-to-back adds with a three-cycle consumer stall.
        got_q.delete();
        fork
            begin
                for (int i = 0; i < 8; i++) send(i, i, 2'b00, 1'b0);
            end
            begin
                repeat (5) @(posedge clk);
                #2 ordy = 1'b0;
                repeat (3) @(posedge clk);
                #2 ordy = 1'b1;
            end
        join
        drain("stream_drain");
        chk("stream_count", got_q.size(), 8);
        for (int i = 0; i < 8; i++) chk("stream_order", got_q[i], 2 * i);

        // Asynchronous reset with three operations in flight.
        send(64'd100, 64'd23, 2'b00, 1'b0);
        send(64'd9, 64'd4, 2'b01, 1'b0);
        send(64'd1, 64'd1, 2'b00, 1'b0);
        for (int n = 0; n < 10 && !ov; n++) begin
            @(posedge clk);
            #1;
        end
        chk("pre_reset_valid", ov, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk("async_reset_outputs", {ov, oc, ovf, zr, res}, 36'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        for (int n = 0; n < 10; n++) begin
            @(posedge clk);
            #1 chk("post_reset_quiet", ov, 1'b0);
        end

        // Random traffic with bubbles and random consumer stalls.
        fork
            begin
                for (int n = 0; n < 3000; n++) begin
                    if ($urandom_range(0, 4) == 0) begin
                        @(posedge clk);
                        #1;
                    end
                    send(pick(), pick(), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #2 ordy = ($urandom_range(0, 9) < 7);
                end
            end
        join
        ordy = 1'b1;
        drain("random_drain");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
